// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light phase timer and its controller:
// phase encoding, default timing constants and the timer FSM state type.
package traffic_pkg;

    // Phase encoding shared with the traffic-light controller.
    typedef enum logic [1:0] {
        PH_IDLE   = 2'b00,
        PH_RED    = 2'b01,
        PH_YELLOW = 2'b10,
        PH_GREEN  = 2'b11
    } phase_t;

    // Timer FSM states, exported on the debug state output.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOAD   = 2'b01,
        ST_COUNT  = 2'b10,
        ST_EXPIRE = 2'b11
    } timer_state_t;

    // Default timing constants.
    localparam int DEF_TICK_DIV  = 4;
    localparam int DEF_RED_TICKS = 2;
    localparam int DEF_YEL_TICKS = 1;
    localparam int DEF_GRN_TICKS = 4;
    localparam int DEF_PED_EXTRA = 3;

    // Map the one-hot light outputs to a phase; anything not one-hot
    // (all-zero or multi-hot) maps to PH_IDLE and is treated as invalid.
    function automatic phase_t decode_phase(input logic r, input logic y, input logic g);
        phase_t p;
        case ({r, y, g})
            3'b100:  p = PH_RED;
            3'b010:  p = PH_YELLOW;
            3'b001:  p = PH_GREEN;
            default: p = PH_IDLE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/traffic_phase_timer_if.sv
// Signal bundle between the traffic-light controller (master) and the
// phase timer (slave). ped_req exists only when TRAFFIC_TIMER_PED_EXT_EN
// is defined.
//
// Protocol: there is no valid/ready handshake. The controller presents its
// one-hot lights and en every cycle; the timer answers with registered
// single-cycle expiry strobes (cou1 yellow, cou2 red, cou4 green) that the
// controller samples on the next clock edge and reacts to by changing phase.
interface traffic_phase_timer_if #(
    parameter int CNT_W = 8
) ();

    logic                        en;
    logic                        r;
    logic                        y;
    logic                        g;
`ifdef TRAFFIC_TIMER_PED_EXT_EN
    logic                        ped_req;
`endif
    logic                        cou1;
    logic                        cou2;
    logic                        cou4;
    logic [CNT_W-1:0]            ticks_left;
    logic                        busy;
    logic                        phase_err;
    traffic_pkg::timer_state_t   state;

    modport master (
        output en, r, y, g,
`ifdef TRAFFIC_TIMER_PED_EXT_EN
        output ped_req,
`endif
        input  cou1, cou2, cou4, ticks_left, busy, phase_err, state
    );

    modport slave (
        input  en, r, y, g,
`ifdef TRAFFIC_TIMER_PED_EXT_EN
        input  ped_req,
`endif
        output cou1, cou2, cou4, ticks_left, busy, phase_err, state
    );

endinterface

// File: rtl/traffic_prescaler.sv
// Clock prescaler: while run is high, counts clk cycles and emits a one-cycle
// tick every TICK_DIV cycles. clear restarts the count from zero; when run
// is low the count holds.
module traffic_prescaler #(
    parameter int PRE_W    = 16,
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    logic [PRE_W-1:0] cnt;

    // Tick on the cycle the counter sits at its last value.
    assign tick = run && (cnt == PRE_W'(TICK_DIV - 1));

    // Prescale counter: wraps on tick, holds while not running.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + PRE_W'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_timer.sv
// Phase timer beside the traffic-light controller. Measures each light phase
// in prescaled ticks, restarts on every phase change and issues one-cycle
// expiry strobes. Optional feature macro: TRAFFIC_TIMER_PED_EXT_EN adds the
// ped_req input, which extends a red phase once by PED_EXTRA ticks.
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int PRE_W     = 16,
    parameter int CNT_W     = 8,
    parameter int RED_TICKS = DEF_RED_TICKS,
    parameter int YEL_TICKS = DEF_YEL_TICKS,
    parameter int GRN_TICKS = DEF_GRN_TICKS
`ifdef TRAFFIC_TIMER_PED_EXT_EN
    ,
    parameter int PED_EXTRA = DEF_PED_EXTRA
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    traffic_phase_timer_if.slave tif
);

    timer_state_t      state, next_state;
    phase_t            cur_phase, prev_phase;
    logic              phase_ok, same_phase;
    logic              run, tick, pre_clear, last_tick, ped_hit;
    logic [CNT_W-1:0]  tick_cnt, ticks_left, dur_q, dur_eff, ticks_nxt;
    logic              cou1_q, cou2_q, cou4_q, phase_err_q;

    // A zero duration would never expire; treat it as one tick.
    function automatic logic [CNT_W-1:0] clamp1(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    function automatic logic [CNT_W-1:0] dur_of(input phase_t p);
        logic [CNT_W-1:0] d;
        case (p)
            PH_RED:    d = clamp1(CNT_W'(RED_TICKS));
            PH_YELLOW: d = clamp1(CNT_W'(YEL_TICKS));
            PH_GREEN:  d = clamp1(CNT_W'(GRN_TICKS));
            default:   d = CNT_W'(1);
        endcase
        return d;
    endfunction

`ifdef TRAFFIC_TIMER_PED_EXT_EN
    logic ped_ext;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W + 1)'(PED_EXTRA);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    // One extension per red phase, taken on any COUNT cycle of red.
    assign ped_hit = (state == ST_COUNT) && tif.en && (prev_phase == PH_RED)
                     && tif.ped_req && !ped_ext;
`else
    assign ped_hit = 1'b0;
`endif

    assign cur_phase  = decode_phase(tif.r, tif.y, tif.g);
    assign phase_ok   = (cur_phase != PH_IDLE);
    assign same_phase = phase_ok && (cur_phase == prev_phase);
    // The prescaler only advances while the measured phase is still shown;
    // an invalid light pattern freezes it in place.
    assign run        = (state == ST_COUNT) && tif.en && same_phase;
    assign pre_clear  = (state != ST_COUNT);

    traffic_prescaler #(
        .PRE_W    (PRE_W),
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (pre_clear),
        .run   (run),
        .tick  (tick)
    );

    // Effective duration and next ticks_left, including any pedestrian extension.
    always_comb begin
        dur_eff   = dur_q;
        ticks_nxt = ticks_left;
        if (run && tick) begin
            ticks_nxt = ticks_left - CNT_W'(1);
        end
`ifdef TRAFFIC_TIMER_PED_EXT_EN
        if (ped_hit) begin
            dur_eff   = sat_add(dur_q);
            ticks_nxt = sat_add(ticks_nxt);
        end
`endif
    end

    assign last_tick = tick && (tick_cnt == dur_eff - CNT_W'(1));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic; dropping en always returns to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (tif.en && phase_ok) next_state = ST_LOAD;
            end
            ST_LOAD: begin
                if (!tif.en)       next_state = ST_IDLE;
                else if (phase_ok) next_state = ST_COUNT;
            end
            ST_COUNT: begin
                if (!tif.en)              next_state = ST_IDLE;
                else if (!phase_ok)       next_state = ST_COUNT;
                else if (!same_phase)     next_state = ST_LOAD;
                else if (last_tick)       next_state = ST_EXPIRE;
            end
            ST_EXPIRE: begin
                if (!tif.en)                     next_state = ST_IDLE;
                else if (phase_ok && !same_phase) next_state = ST_LOAD;
                else                             next_state = ST_COUNT;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Phase bookkeeping and tick counters.
    always_ff @(posedge clk) begin
        if (!reset || (next_state == ST_IDLE)) begin
            tick_cnt   <= '0;
            ticks_left <= '0;
            dur_q      <= '0;
            prev_phase <= PH_IDLE;
`ifdef TRAFFIC_TIMER_PED_EXT_EN
            ped_ext    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_LOAD: begin
`ifdef TRAFFIC_TIMER_PED_EXT_EN
                    ped_ext <= 1'b0;
`endif
                    if (next_state == ST_COUNT) begin
                        tick_cnt   <= '0;
                        ticks_left <= dur_of(cur_phase);
                        dur_q      <= dur_of(cur_phase);
                        prev_phase <= cur_phase;
                    end
                end
                ST_COUNT: begin
                    if (next_state != ST_LOAD) begin
                        if (run && tick) tick_cnt <= tick_cnt + CNT_W'(1);
                        ticks_left <= ticks_nxt;
                        dur_q      <= dur_eff;
`ifdef TRAFFIC_TIMER_PED_EXT_EN
                        if (ped_hit) ped_ext <= 1'b1;
`endif
                    end
                end
                ST_EXPIRE: begin
                    // Phase held by the controller: rearm for a periodic re-expiry.
                    if (next_state == ST_COUNT) begin
                        tick_cnt   <= '0;
                        ticks_left <= dur_of(prev_phase);
                        dur_q      <= dur_of(prev_phase);
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered strobes (high for the single EXPIRE cycle) and phase error.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cou1_q      <= 1'b0;
            cou2_q      <= 1'b0;
            cou4_q      <= 1'b0;
            phase_err_q <= 1'b0;
        end else begin
            cou1_q      <= (next_state == ST_EXPIRE) && (prev_phase == PH_YELLOW);
            cou2_q      <= (next_state == ST_EXPIRE) && (prev_phase == PH_RED);
            cou4_q      <= (next_state == ST_EXPIRE) && (prev_phase == PH_GREEN);
            phase_err_q <= tif.en && !phase_ok;
        end
    end

    assign tif.cou1       = cou1_q;
    assign tif.cou2       = cou2_q;
    assign tif.cou4       = cou4_q;
    assign tif.phase_err  = phase_err_q;
    assign tif.ticks_left = ticks_left;
    assign tif.busy       = (state != ST_IDLE);
    assign tif.state      = state;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed self-checking bench for traffic_phase_timer with default
// parameters (TICK_DIV=4, red 2, yellow 1, green 4 ticks).
module tb_traffic_phase_timer;
    import traffic_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    traffic_phase_timer_if #(.CNT_W(8)) tif ();

    traffic_phase_timer dut (
        .clk   (clk),
        .reset (reset),
        .tif   (tif)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [2:0]  strobe_q[$];
    logic [2:0]  light_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] strobes();
        return {tif.cou4, tif.cou2, tif.cou1};
    endfunction

    // ---------------- driver tasks ----------------
    // ryg is {r, y, g}; applied on the falling edge.
    task automatic drive(input logic e, input logic [2:0] ryg);
        @(negedge clk);
        tif.en = e;
        {tif.r, tif.y, tif.g} = ryg;
    endtask

    task automatic go_idle();
        drive(1'b0, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        check("idle_state", 32'(tif.state), 32'(ST_IDLE));
    endtask

    // Counts rising edges until a strobe; n is -1 when the budget runs out.
    task automatic wait_strobe(input int start, output int n, output logic [2:0] which);
        n = -1;
        which = 3'b000;
        for (int c = start; c < start + 200; c++) begin
            @(posedge clk);
            #1;
            if (strobes() != 3'b000) begin
                n = c;
                which = strobes();
                break;
            end
        end
    endtask

    task automatic count_strobes(input int cycles, output int seen);
        seen = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            if (strobes() != 3'b000) seen++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    int         n;
    int         seen;
    logic [2:0] w;
    logic [2:0] light;

    initial begin
        reset  = 1'b0;
        tif.en = 1'b0;
        tif.r  = 1'b0;
        tif.y  = 1'b0;
        tif.g  = 1'b0;
`ifdef TRAFFIC_TIMER_PED_EXT_EN
        tif.ped_req = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(tif.state), 32'(ST_IDLE));
        check("rst_busy", 32'(tif.busy), 0);
        check("rst_ticks", 32'(tif.ticks_left), 0);
        check("rst_strobes", 32'(strobes()), 0);
        check("rst_err", 32'(tif.phase_err), 0);
        @(negedge clk);
        reset = 1'b1;

        // Red from idle: LOAD + 2*4 COUNT cycles.
        drive(1'b1, 3'b100);
        wait_strobe(0, n, w);
        check("red_latency", 32'(n), 9);
        check("red_strobe", 32'(w), 2);
        @(posedge clk);
        #1;
        check("red_strobe_width", 32'(strobes()), 0);

        // Model controller: red -> yellow -> green -> yellow, each phase
        // change applied in the cycle the strobe is seen.
        go_idle();
        light_q = '{3'b100, 3'b010, 3'b001, 3'b010};
        exp_q.push_back(9);  strobe_q.push_back(3'b010);
        exp_q.push_back(5);  strobe_q.push_back(3'b001);
        exp_q.push_back(17); strobe_q.push_back(3'b100);
        exp_q.push_back(5);  strobe_q.push_back(3'b001);
        while (light_q.size() > 0) begin
            light = light_q.pop_front();
            drive(1'b1, light);
            wait_strobe(0, n, w);
            check("seq_latency", 32'(n), exp_q.pop_front());
            check("seq_strobe", 32'(w), 32'(strobe_q.pop_front()));
        end

        // Green held: first expiry, then periodic re-expiry every 17 cycles.
        drive(1'b1, 3'b001);
        wait_strobe(0, n, w);
        check("grn_latency", 32'(n), 17);
        wait_strobe(1, n, w);
        check("grn_period1", 32'(n), 17);
        check("grn_period1_strobe", 32'(w), 4);
        wait_strobe(1, n, w);
        check("grn_period2", 32'(n), 17);

        // en dropped in cycle 6 of red.
        go_idle();
        drive(1'b1, 3'b100);
        for (int c = 0; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) check("drop_load_ticks", 32'(tif.ticks_left), 2);
        end
        check("drop_mid_ticks", 32'(tif.ticks_left), 1);
        check("drop_mid_busy", 32'(tif.busy), 1);
        drive(1'b0, 3'b100);
        @(posedge clk);
        #1;
        check("drop_busy", 32'(tif.busy), 0);
        check("drop_ticks", 32'(tif.ticks_left), 0);
        check("drop_state", 32'(tif.state), 32'(ST_IDLE));
        count_strobes(12, seen);
        check("drop_no_strobe", 32'(seen), 0);

        // en dropped in the last COUNT cycle, just before EXPIRE.
        drive(1'b1, 3'b100);
        repeat (9) @(posedge clk);
        drive(1'b0, 3'b100);
        count_strobes(12, seen);
        check("late_drop_no_strobe", 32'(seen), 0);
        check("late_drop_state", 32'(tif.state), 32'(ST_IDLE));

        // Multi-hot lights freeze the count for 5 cycles.
        go_idle();
        drive(1'b1, 3'b100);
        n = -1;
        w = 3'b000;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (c == 4) begin
                check("err_set", 32'(tif.phase_err), 1);
                check("err_ticks", 32'(tif.ticks_left), 2);
            end
            if (c == 8) check("err_frozen_ticks", 32'(tif.ticks_left), 2);
            if (c == 9) check("err_clear", 32'(tif.phase_err), 0);
            if (strobes() != 3'b000) begin
                n = c;
                w = strobes();
                break;
            end
            if (c == 3) drive(1'b1, 3'b101);
            if (c == 8) drive(1'b1, 3'b100);
        end
        check("err_latency", 32'(n), 14);
        check("err_strobe", 32'(w), 2);

        // Phase change mid-count aborts red; green restarts from LOAD.
        go_idle();
        drive(1'b1, 3'b100);
        repeat (5) @(posedge clk);
        drive(1'b1, 3'b001);
        wait_strobe(0, n, w);
        check("abort_latency", 32'(n), 17);
        check("abort_strobe", 32'(w), 4);

        // Reset during COUNT wins; timing restarts after release.
        go_idle();
        drive(1'b1, 3'b100);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_state", 32'(tif.state), 32'(ST_IDLE));
        check("midrst_busy", 32'(tif.busy), 0);
        check("midrst_ticks", 32'(tif.ticks_left), 0);
        @(negedge clk);
        reset = 1'b1;
        wait_strobe(0, n, w);
        check("midrst_latency", 32'(n), 9);

`ifdef TRAFFIC_TIMER_PED_EXT_EN
        // Pedestrian extension: (2+3)*4+1 cycles; second request ignored.
        go_idle();
        drive(1'b1, 3'b100);
        n = -1;
        w = 3'b000;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (c == 3) check("ped_ticks", 32'(tif.ticks_left), 5);
            if (c == 7) check("ped_second_ignored", 32'(tif.ticks_left), 4);
            if (strobes() != 3'b000) begin
                n = c;
                w = strobes();
                break;
            end
            if (c == 2 || c == 6) begin
                @(negedge clk);
                tif.ped_req = 1'b1;
            end else begin
                @(negedge clk);
                tif.ped_req = 1'b0;
            end
        end
        check("ped_latency", 32'(n), 21);
        check("ped_strobe", 32'(w), 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
